// File: rtl/div_sequencer.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on |rs1| / |rs2|; sign fix-up on the way into DONE.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | 32 shift-subtract iterations, count 0..31
// DONE  | done pulse, result valid
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic        op_rem;
  logic        negate;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;

  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        div_zero;
  logic        ovf;
  logic [31:0] special_res;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] fix_src;
  logic [31:0] final_res;

  assign stall = start & ~done & ~flush;

  assign is_signed   = ~op[0];
  assign abs_a       = (is_signed & rs1_data[31]) ? (32'd0 - rs1_data) : rs1_data;
  assign abs_b       = (is_signed & rs2_data[31]) ? (32'd0 - rs2_data) : rs2_data;
  assign div_zero    = (rs2_data == 32'd0);
  assign ovf         = is_signed & (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF);
  assign special_res = div_zero ? (op[1] ? rs1_data : 32'hFFFF_FFFF)
                                : (op[1] ? 32'd0    : 32'h8000_0000);

  // Remainder stays below the divisor, so the shifted value fits in 33 bits.
  assign rem_sh    = {rem, quo[31]};
  assign diff      = rem_sh - {1'b0, divisor};
  assign rem_nxt   = diff[32] ? rem_sh[31:0] : diff[31:0];
  assign quo_nxt   = {quo[30:0], ~diff[32]};
  assign fix_src   = op_rem ? rem_nxt : quo_nxt;
  assign final_res = negate ? (32'd0 - fix_src) : fix_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 5'd0;
      op_rem  <= 1'b0;
      negate  <= 1'b0;
      divisor <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
      count <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_rem  <= op[1];
            negate  <= op[1] ? (is_signed & rs1_data[31])
                             : (is_signed & (rs1_data[31] ^ rs2_data[31]));
            divisor <= abs_b;
            rem     <= 32'd0;
            quo     <= abs_a;
            count   <= 5'd0;
            busy    <= 1'b1;
            if (div_zero | ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= special_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= final_res;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and random checks of div_sequencer: results, latency, flush and reset.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_result = 32'd0;

  div_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic of;
    sa = a;
    sb = b;
    of = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : of ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   model = (b == 0) ? a : of ? 32'd0 : 32'(sa % sb);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one request (start held until done) and checks latency/result.
  task automatic run_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string tag);
    int cyc;
    logic stall_ok;
    logic [31:0] want;
    op = o; rs1_data = a; rs2_data = b; start = 1'b1;
    sb_q.push_back(exp);
    #1;
    check({tag, " stall_on_start"}, {31'd0, stall}, 32'd1);
    cyc = 0;
    stall_ok = 1'b1;
    do begin
      step();
      cyc++;
      if (!done && !stall) stall_ok = 1'b0;
    end while (!done && cyc < 100);
    check({tag, " latency"}, cyc, lat);
    check({tag, " stall_held"}, {31'd0, stall_ok}, 32'd1);
    want = sb_q.pop_front();
    check({tag, " result"}, result, want);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
    check({tag, " stall_at_done"}, {31'd0, stall}, 32'd0);
    last_result = want;
    start = 1'b0;
    step();
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic        spec;

    step(); step();
    rst = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);

    run_div(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run_div(2'b11, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    run_div(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_div(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_div(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
    run_div(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
    run_div(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run_div(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "rem_by0");
    run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    // Flush at CALC count 10.
    op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
    for (int i = 0; i < 11; i++) step();
    check("flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1; start = 1'b0;
    step();
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result_held", result, last_result);
    run_div(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_after_flush");

    // Flush together with start in IDLE must not be accepted.
    op = 2'b01; rs1_data = 32'd50; rs2_data = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start stall", {31'd0, stall}, 32'd0);
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", {31'd0, busy}, 32'd0);

    // Reset at CALC count 20.
    op = 2'b01; rs1_data = 32'd999; rs2_data = 32'd4; start = 1'b1;
    for (int i = 0; i < 21; i++) step();
    rst = 1'b1; start = 1'b0;
    step();
    rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst stall", {31'd0, stall}, 32'd0);
    run_div(2'b01, 32'd81, 32'd9, 32'd9, 33, "b2b_1");
    run_div(2'b01, 32'hDEAD_BEEF, 32'd16, 32'h0DEA_DBEE, 33, "b2b_2");

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 4 == 1) ra = -ra;
      spec = (rb == 0) || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF);
      run_div(ro, ra, rb, model(ro, ra, rb), spec ? 1 : 33, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative 32-cycle sequencer and shift-subtract datapath for the RV32M divide group (DIV, DIVU, REM, REMU). It sits beside the EX-stage ALU/multiplier and is started by the EX-stage controls. It holds the pipeline through a stall line until the result is ready. One divide is in flight at a time; operands are latched on acceptance.

## Interface
- No parameters (XLEN fixed at 32).
- clk  in  1  clock; everything sampled on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  EX instruction is a divide; held high until `done`.
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data  in  32  dividend (forwarded value).
- rs2_data  in  32  divisor (forwarded value).
- flush  in  1  kill the in-flight divide (branch/jump taken in pipeline).
- stall  out  1  freeze IF/ID/EX; combinational: `start & ~done & ~flush`.
- busy  out  1  registered; high in CALC and DONE.
- done  out  1  registered; one-cycle pulse, `result` valid.
- result  out  32  quotient or remainder; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, DONE. Reset and flush both force IDLE.
- **IDLE**
  - Accept when `start & ~flush`.
  - Latch op, signs, |rs1|, |rs2|.
  - Clear remainder register; load quotient register with |rs1|; clear count.
  - Divisor == 0 or (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF) → go straight to DONE.
  - Otherwise → CALC.
- **CALC**, one iteration per cycle:
  - Shift {rem,quo} left 1.
  - Trial subtract: diff = rem_shifted − divisor, computed 33 bits wide.
  - diff non-negative → rem = diff, quo[0] = 1; else quo[0] = 0.
  - count increments 0→31; after the iteration at count 31 → DONE.
- **DONE**
  - Drive `done` = 1 and `result`, then → IDLE unconditionally.
- Sign fix-up, applied in the cycle entering DONE:
  - Quotient is negated if op is DIV and the signs of rs1 and rs2 differ.
  - Remainder is negated if op is REM and rs1 is negative.
- Special results:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- A `start` high in the IDLE cycle right after DONE is a new request. The pipeline must have advanced by then.
- Flush:
  - Flush in any state → IDLE next cycle, no `done`, `result` unchanged.
  - Flush together with `start` in IDLE → not accepted.
- `rs1_data`, `rs2_data` and `op` are ignored outside IDLE.

## Timing
- Reset values:
  - State: IDLE.
  - `busy` = 0, `done` = 0, `result` = 0.
  - count = 0; operand registers = 0.
  - `stall` follows `start` and is 0 when `start` = 0.
- Normal latency: accepted at edge T → CALC covers cycles T+1..T+32 → `done` = 1 in cycle T+33. `stall` is high from first `start` through T+32.
- Special-case latency: `done` = 1 in cycle T+1.
- `busy` rises in cycle T+1 and falls in the cycle after `done`.
- Flush latency: flush sampled at edge F → IDLE and `busy` = 0 in cycle F+1.
- Reset mid-operation: IDLE next cycle, no `done`.

## Test plan
- DIVU 100 / 7 accepted at T → `done` at T+33, `result` = 14; REMU same operands → 2.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIV 7 / −2 → 0xFFFFFFFD; REM 7 / −2 → 1.
- DIVU 0x12345678 / 0 → `done` at T+1, `result` 0xFFFFFFFF; REM 0x12345678 / 0 → 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1; REM with same operands → 0.
- Flush asserted at CALC count 10:
  - Expect no `done` and `busy` = 0 next cycle.
  - Then DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF with full 33-cycle latency.
- `rst` at CALC count 20 → all outputs at reset values next cycle; back-to-back DIVU requests after `done` each take 33 cycles.
